// File: rtl/vtg_pkg.sv
// Shared video timing types, default mode constants and total helpers.
// Consumed by video_timing_gen, vtg_delay_line and downstream pipe stages.
package vtg_pkg;

    localparam int X_ACTIVE_720 = 1280;
    localparam int HFP_720      = 110;
    localparam int HSW_720      = 40;
    localparam int HBP_720      = 220;
    localparam int Y_ACTIVE_720 = 720;
    localparam int VFP_720      = 5;
    localparam int VSW_720      = 5;
    localparam int VBP_720      = 20;

    localparam int X_ACTIVE_480 = 640;
    localparam int HFP_480      = 16;
    localparam int HSW_480      = 96;
    localparam int HBP_480      = 48;
    localparam int Y_ACTIVE_480 = 480;
    localparam int VFP_480      = 10;
    localparam int VSW_480      = 2;
    localparam int VBP_480      = 33;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
        logic lineStart;
        logic frameStart;
    } vtg_sig_t;

    function automatic int h_total(int xa, int hfp, int hsw, int hbp);
        return xa + hfp + hsw + hbp;
    endfunction

    function automatic int v_total(int ya, int vfp, int vsw, int vbp);
        return ya + vfp + vsw + vbp;
    endfunction

endpackage

// File: rtl/vtg_delay_line.sv
// Pixel-enable qualified shift register for the video timing bundle.
// Every stage resets to the supplied inactive value.
module vtg_delay_line
    import vtg_pkg::*;
#(
    parameter int       DEPTH = 2,
    parameter vtg_sig_t INIT  = '0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     en,
    input  vtg_sig_t d,
    output vtg_sig_t q
);

    vtg_sig_t stg [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= INIT;
            end
        end else if (en) begin
            stg[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Pipe-0 raster counters with de/hsync/vsync and line/frame strobes.
// Define VTG_LOOKAHEAD_EN to delay the timing bundle LEAD pixels behind x/y.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int X_ACTIVE = X_ACTIVE_720,
    parameter int HFP      = HFP_720,
    parameter int HSW      = HSW_720,
    parameter int HBP      = HBP_720,
    parameter int Y_ACTIVE = Y_ACTIVE_720,
    parameter int VFP      = VFP_720,
    parameter int VSW      = VSW_720,
    parameter int VBP      = VBP_720,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 12,
    parameter int LEAD     = 2
) (
    input  logic          pixelInc,
    input  logic          reset,
    input  logic          pixelEn,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          lineStart,
    output logic          frameStart
);

    localparam int H_TOTAL = h_total(X_ACTIVE, HFP, HSW, HBP);
    localparam int V_TOTAL = v_total(Y_ACTIVE, VFP, VSW, VBP);

    localparam logic [CW-1:0] X_MAX  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_MAX  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] X_ACT  = CW'(X_ACTIVE);
    localparam logic [CW-1:0] Y_ACT  = CW'(Y_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(X_ACTIVE + HFP);
    localparam logic [CW-1:0] HS_END = CW'(X_ACTIVE + HFP + HSW);
    localparam logic [CW-1:0] VS_BEG = CW'(Y_ACTIVE + VFP);
    localparam logic [CW-1:0] VS_END = CW'(Y_ACTIVE + VFP + VSW);

    localparam vtg_sig_t IDLE = '{
        de:         1'b0,
        hsync:      ~HS_POL,
        vsync:      ~VS_POL,
        lineStart:  1'b0,
        frameStart: 1'b0
    };

    if (H_TOTAL > (1 << CW)) begin : g_chk_h
        $error("H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (1 << CW)) begin : g_chk_v
        $error("V_TOTAL does not fit in CW bits");
    end
    if (HBP < 1 || VBP < 1 || LEAD < 1) begin : g_chk_min
        $error("HBP, VBP and LEAD must be at least 1");
    end

    logic [CW-1:0] x_q, y_q;
    logic [CW-1:0] x_nxt, y_nxt;
    vtg_sig_t      sig_nxt, sig_q, sig_o;

    always_comb begin
        x_nxt = x_q + 1'b1;
        y_nxt = y_q;
        if (x_q == X_MAX) begin
            x_nxt = '0;
            y_nxt = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
        end
    end

    // Decode from the next count so the bundle lines up with x/y.
    always_comb begin
        sig_nxt            = IDLE;
        sig_nxt.de         = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
        sig_nxt.hsync      = (x_nxt >= HS_BEG && x_nxt < HS_END) ?
                             HS_POL : ~HS_POL;
        sig_nxt.vsync      = (y_nxt >= VS_BEG && y_nxt < VS_END) ?
                             VS_POL : ~VS_POL;
        sig_nxt.lineStart  = (x_nxt == '0);
        sig_nxt.frameStart = (x_nxt == '0) && (y_nxt == '0);
    end

    always_ff @(posedge pixelInc) begin
        if (reset) begin
            x_q   <= X_MAX;
            y_q   <= Y_MAX;
            sig_q <= IDLE;
        end else if (pixelEn) begin
            x_q   <= x_nxt;
            y_q   <= y_nxt;
            sig_q <= sig_nxt;
        end
    end

`ifdef VTG_LOOKAHEAD_EN
    vtg_delay_line #(
        .DEPTH (LEAD),
        .INIT  (IDLE)
    ) u_dly (
        .clk   (pixelInc),
        .reset (reset),
        .en    (pixelEn),
        .d     (sig_q),
        .q     (sig_o)
    );
`else
    assign sig_o = sig_q;
`endif

    assign x          = x_q;
    assign y          = y_q;
    assign de         = sig_o.de;
    assign hsync      = sig_o.hsync;
    assign vsync      = sig_o.vsync;
    assign lineStart  = sig_o.lineStart;
    assign frameStart = sig_o.frameStart;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised scoreboard bench for video_timing_gen on a tiny 8x6 raster.
// Reference model counts advances since reset and derives outputs from that.
module tb_video_timing_gen;

    localparam int XA = 4, HF = 1, HW = 2, HB = 1;
    localparam int YA = 3, VF = 1, VW = 1, VB = 1;
    localparam int HT = XA + HF + HW + HB;
    localparam int VT = YA + VF + VW + VB;
    localparam int FT = HT * VT;
    localparam bit HP = 1'b0, VP = 1'b1;
    localparam int CW = 4;
    localparam int LEAD = 2;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          pixelEn;
    logic [CW-1:0] x, y;
    logic          de, hsync, vsync, lineStart, frameStart;

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];
    bit   done = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .X_ACTIVE (XA), .HFP (HF), .HSW (HW), .HBP (HB),
        .Y_ACTIVE (YA), .VFP (VF), .VSW (VW), .VBP (VB),
        .HS_POL   (HP), .VS_POL (VP), .CW (CW), .LEAD (LEAD)
    ) dut (
        .pixelInc   (clk),
        .reset      (reset),
        .pixelEn    (pixelEn),
        .x          (x),
        .y          (y),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync),
        .lineStart  (lineStart),
        .frameStart (frameStart)
    );

    // Timing signals for the n-th advance after reset (n=0: reset state).
    function automatic exp_t timing(int n);
        exp_t e;
        int   p, px, py;
        e = '0;
        e.hs = ~HP;
        e.vs = ~VP;
        if (n > 0) begin
            p  = (n - 1) % FT;
            px = p % HT;
            py = p / HT;
            e.de = (px < XA) && (py < YA);
            e.hs = (px >= XA + HF && px < XA + HF + HW) ? HP : ~HP;
            e.vs = (py >= YA + VF && py < YA + VF + VW) ? VP : ~VP;
            e.ls = (px == 0);
            e.fs = (p == 0);
        end
        return e;
    endfunction

    function automatic exp_t model(int n);
        exp_t e;
        int   p;
`ifdef VTG_LOOKAHEAD_EN
        e = timing(n - LEAD);
`else
        e = timing(n);
`endif
        p   = (n + FT - 1) % FT;
        e.x = 4'(p % HT);
        e.y = 4'(p / HT);
        return e;
    endfunction

    int n_adv = 0;

    task automatic step(input logic rst, input logic en);
        reset   = rst;
        pixelEn = en;
        if (rst)     n_adv = 0;
        else if (en) n_adv++;
        sb.push_back(model(n_adv));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g = {x, y, de, hsync, vsync, lineStart, frameStart};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b exp x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                         $time, g.x, g.y, g.de, g.hs, g.vs, g.ls, g.fs,
                         e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs);
            end
        end
    end

    initial begin
        int wait_cyc;
        reset   = 1'b1;
        pixelEn = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", sb.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised successor to the pipe-0 pixel counter. Generates the horizontal and vertical raster counters and the derived video timing: data enable, hsync and vsync with programmable porches, sync widths and polarity, plus line-start and frame-start strobes. It sits at the head of the GPU pipeline (pipe 0) and feeds coordinates and timing to later stages. An optional lookahead delay line lets downstream stages fetch pixel data ahead of the display timing.

## Interface
- X_ACTIVE, 1280: active pixels per line
- HFP, 110: horizontal front porch, in pixels
- HSW, 40: hsync width, in pixels
- HBP, 220: horizontal back porch, in pixels; must be ≥1
- Y_ACTIVE, 720: active lines per frame
- VFP, 5: vertical front porch, in lines
- VSW, 5: vsync width, in lines
- VBP, 20: vertical back porch, in lines; must be ≥1
- HS_POL, 1: hsync active level
- VS_POL, 1: vsync active level
- CW, 12: counter width; must hold H_TOTAL-1 and V_TOTAL-1
- LEAD, 2: lookahead depth in pixels; used only with VTG_LOOKAHEAD_EN; must be ≥1
- pixelInc, in, 1: clock; the only clock
- reset, in, 1: synchronous, active-high reset
- pixelEn, in, 1: advance enable; counters and the delay line move only when this is high
- x, out, CW: horizontal counter, 0..H_TOTAL-1
- y, out, CW: vertical counter, 0..V_TOTAL-1
- de, out, 1: high when x<X_ACTIVE and y<Y_ACTIVE
- hsync, out, 1: HS_POL when x is in [X_ACTIVE+HFP, X_ACTIVE+HFP+HSW)
- vsync, out, 1: VS_POL when y is in [Y_ACTIVE+VFP, Y_ACTIVE+VFP+VSW), held for whole lines
- lineStart, out, 1: high for the one cycle in which x==0
- frameStart, out, 1: high for the one cycle in which x==0 and y==0

## Operation
- H_TOTAL = X_ACTIVE+HFP+HSW+HBP; V_TOTAL = Y_ACTIVE+VFP+VSW+VBP.
- Reset values: x=H_TOTAL-1, y=V_TOTAL-1, de=0, hsync=!HS_POL, vsync=!VS_POL, lineStart=0, frameStart=0. The delay line is cleared to these same inactive values.
- Each pixelEn cycle:
  - x increments; at H_TOTAL-1, x wraps to 0.
  - When x wraps, y increments; at V_TOTAL-1, y wraps to 0.
- The first pixelEn after reset produces x=0, y=0, de=1, lineStart=1, frameStart=1.
- pixelEn low: every output holds its value, and lineStart/frameStart stay at their last value. A strobe is therefore qualified by pixelEn for one pixel, not by one clock.
- All outputs are registered. de, hsync, vsync and the strobes are decoded from the next-count values, so they are aligned with the x/y registers.
- Comparisons use CW-bit unsigned arithmetic. Totals are computed as localparams with no truncation; an elaboration check fails if H_TOTAL > 2^CW or V_TOTAL > 2^CW.
- Reset asserted mid-frame: on the next edge all outputs return to their reset values regardless of pixelEn. reset has priority over pixelEn.

## Timing
- Latency from pixelEn to the updated outputs: 1 pixelInc edge.
- Without the lookahead: de, hsync, vsync and the strobes change on the same edge as x/y.
- With the lookahead: those five signals lag x/y by exactly LEAD pixelEn-qualified advances; x/y are unaffected.
- Frame period: H_TOTAL × V_TOTAL pixelEn cycles. There are no gaps or extra cycles at either wrap.

## Configuration
- VTG_LOOKAHEAD_EN defined:
  - de, hsync, vsync, lineStart and frameStart pass through a LEAD-stage shift register that advances only on pixelEn.
  - x/y then lead the display timing by LEAD pixels, giving the fetch stages time to prefetch.
- VTG_LOOKAHEAD_EN undefined: no delay line is built, LEAD is ignored, and the outputs are as in Operation.

## Structure
- Shared package vtg_pkg holds:
  - the default timing constants for 1280x720 and 640x480;
  - functions computing H_TOTAL and V_TOTAL;
  - a packed struct vtg_sig_t {de, hsync, vsync, lineStart, frameStart} used by the delay line and by downstream stages.
- One sub-module, vtg_delay_line: parametrised depth, element type vtg_sig_t, enable input, synchronous reset to an inactive value. It is instantiated only under VTG_LOOKAHEAD_EN.

## Test plan
Small bench configuration: X_ACTIVE=4, HFP=1, HSW=2, HBP=1 (H_TOTAL=8); Y_ACTIVE=3, VFP=1, VSW=1, VBP=1 (V_TOTAL=6); HS_POL=0, VS_POL=1; CW=4.
- Release reset, pixelEn=1: first edge gives x=0, y=0, de=1, lineStart=1, frameStart=1, hsync=1, vsync=0.
- Run one line: de high for x=0..3; hsync=0 exactly at x=5 and x=6; y goes 0→1 on the edge where x goes 7→0, with lineStart=1.
- Run 48 pixels: vsync=1 for all 8 pixels of y=4 only; frameStart reasserts on the 49th pixel with x=0, y=0.
- Toggle pixelEn 1-0-0-1 mid-line at x=2: x holds at 2 for two cycles, then advances to 3; de stays stable throughout.
- Assert reset at x=6, y=4 for one cycle: the outputs return to x=7, y=5, de=0, hsync=1, vsync=0, and the next pixelEn gives frameStart=1.
- With VTG_LOOKAHEAD_EN, LEAD=2: de rises 2 pixels after x=0, y=0 appears, and frameStart lags x=0, y=0 by 2 pixels.
